// File: rtl/seq_detect_nonoverlap_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_nonoverlap_if
// Brief    : Bit-stream input and count/pulse/state outputs of the
//            non-overlapping serial sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_nonoverlap_if #(
    parameter int PATTERN_LEN = 4,
    parameter int COUNT_W     = 8
);
    localparam int SW = $clog2(PATTERN_LEN + 1);

    logic               clear;
    logic               bit_valid;
    logic               bit_in;
    logic [COUNT_W-1:0] pattern_count;
    logic               match_pulse;
    logic [SW-1:0]      match_state;

    // Producer of the bit stream and consumer of the results
    modport master (
        output clear,
        output bit_valid,
        output bit_in,
        input  pattern_count,
        input  match_pulse,
        input  match_state
    );

    // The detector itself
    modport slave (
        input  clear,
        input  bit_valid,
        input  bit_in,
        output pattern_count,
        output match_pulse,
        output match_state
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_nonoverlap.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_nonoverlap
// Brief    : Serial non-overlapping pattern detector with a saturating match
//            counter. Prefix-tracking FSM whose mismatch fallback table is
//            derived from PATTERN at elaboration; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_nonoverlap #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     COUNT_W     = 8
) (
    input  wire logic                 clock_100Mhz,
    input  wire logic                 reset,
    seq_detect_nonoverlap_if.slave    bus
);

    localparam int                   c_SW        = $clog2(PATTERN_LEN + 1);
    localparam int                   c_TBL       = 2 ** c_SW;
    localparam logic [c_SW-1:0]      c_LAST      = c_SW'(PATTERN_LEN - 1);
    localparam logic [COUNT_W-1:0]   c_COUNT_MAX = '1;

    // Longest proper suffix of (first k pattern bits, b) that is also a
    // pattern prefix. Only used for the mismatch case, so lengths up to k.
    function automatic logic [c_SW-1:0] f_fallback(input int k, input logic b);
        logic [PATTERN_LEN-1:0] t_s;
        logic [PATTERN_LEN-1:0] t_p;
        logic                   s_bit;
        logic                   ok;
        int                     best;
        best = 0;
        for (int len = 1; len <= k; len++) begin
            ok = 1'b1;
            for (int j = 0; j < len; j++) begin
                // Position m of the (k+1)-bit history; the last one is b
                if ((k + 1 - len + j) == k) begin
                    s_bit = b;
                end else begin
                    t_s   = PATTERN >> (PATTERN_LEN - 1 - (k + 1 - len + j));
                    s_bit = t_s[0];
                end
                t_p = PATTERN >> (PATTERN_LEN - 1 - j);
                if (s_bit != t_p[0]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = len;
            end
        end
        return c_SW'(best);
    endfunction

    logic                w_exp_tbl  [c_TBL];
    logic [c_SW-1:0]     w_next_tbl [2*c_TBL];

    logic [c_SW-1:0]     r_state;
    logic [COUNT_W-1:0]  r_count;
    logic                r_pulse;

    // Expected next bit and mismatch fallback for every prefix length;
    // entries beyond PATTERN_LEN-1 are unreachable and tied to zero.
    generate
        for (genvar k = 0; k < c_TBL; k++) begin : g_state
            if (k < PATTERN_LEN) begin : g_used
                assign w_exp_tbl[k]      = PATTERN[PATTERN_LEN-1-k];
                assign w_next_tbl[2*k]   = f_fallback(k, 1'b0);
                assign w_next_tbl[2*k+1] = f_fallback(k, 1'b1);
            end else begin : g_unused
                assign w_exp_tbl[k]      = 1'b0;
                assign w_next_tbl[2*k]   = '0;
                assign w_next_tbl[2*k+1] = '0;
            end
        end
    endgenerate

    // Prefix FSM, saturating counter and one-cycle match pulse; clear acts
    // like reset and swallows any bit presented in the same cycle.
    always_ff @(posedge clock_100Mhz) begin
        if (reset || bus.clear) begin
            r_state <= '0;
            r_count <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (bus.bit_valid) begin
                if (bus.bit_in == w_exp_tbl[r_state]) begin
                    if (r_state == c_LAST) begin
                        // Full match: restart from empty, no suffix reuse
                        r_state <= '0;
                        r_pulse <= 1'b1;
                        if (r_count != c_COUNT_MAX) begin
                            r_count <= r_count + COUNT_W'(1);
                        end
                    end else begin
                        r_state <= r_state + c_SW'(1);
                    end
                end else begin
                    r_state <= w_next_tbl[{r_state, bus.bit_in}];
                end
            end
        end
    end

    assign bus.pattern_count = r_count;
    assign bus.match_pulse   = r_pulse;
    assign bus.match_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_nonoverlap.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_nonoverlap
// Brief    : Scoreboard bench for seq_detect_nonoverlap with PATTERN=1011.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_nonoverlap;

    localparam int              PATTERN_LEN = 4;
    localparam logic [3:0]      PATTERN     = 4'b1011;
    localparam int              COUNT_W     = 8;

    typedef struct {
        logic       pulse;
        int         count;
        int         state;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_detect_nonoverlap_if #(.PATTERN_LEN(PATTERN_LEN), .COUNT_W(COUNT_W)) bus ();

    seq_detect_nonoverlap #(
        .PATTERN_LEN (PATTERN_LEN),
        .PATTERN     (PATTERN),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (rst),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;
    exp_t sb_q[$];
    int   pulse_steps[$];

    // Reference model: history of bits since the last match/reset
    logic m_hist[$];
    int   m_count = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic pat_bit(input int j);
        logic [3:0] t;
        t = PATTERN >> (PATTERN_LEN - 1 - j);
        return t[0];
    endfunction

    // Longest tail of the history (shorter than the pattern) equal to a pattern head
    function automatic int model_state();
        int n;
        int best;
        logic ok;
        n    = m_hist.size();
        best = 0;
        for (int len = 1; len < PATTERN_LEN && len <= n; len++) begin
            ok = 1'b1;
            for (int j = 0; j < len; j++)
                if (m_hist[n - len + j] != pat_bit(j)) ok = 1'b0;
            if (ok) best = len;
        end
        return best;
    endfunction

    function automatic logic model_full();
        int n;
        logic ok;
        n = m_hist.size();
        if (n < PATTERN_LEN) return 1'b0;
        ok = 1'b1;
        for (int j = 0; j < PATTERN_LEN; j++)
            if (m_hist[n - PATTERN_LEN + j] != pat_bit(j)) ok = 1'b0;
        return ok;
    endfunction

    // One clock of stimulus: model predicts, DUT result is compared after the edge
    task automatic step(input logic r, input logic clr, input logic v, input logic b);
        exp_t e;
        exp_t got;
        rst           = r;
        bus.clear     = clr;
        bus.bit_valid = v;
        bus.bit_in    = b;
        e.pulse = 1'b0;
        if (r || clr) begin
            m_hist  = {};
            m_count = 0;
        end else if (v) begin
            m_hist.push_back(b);
            if (model_full()) begin
                e.pulse = 1'b1;
                m_hist  = {};
                if (m_count < 255) m_count++;
            end
            while (m_hist.size() > PATTERN_LEN - 1) void'(m_hist.pop_front());
        end
        e.count = m_count;
        e.state = model_state();
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        if (bus.match_pulse) pulse_steps.push_back(step_no);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            got = sb_q.pop_front();
            check("match_pulse",   int'(bus.match_pulse),   int'(got.pulse));
            check("pattern_count", int'(bus.pattern_count), got.count);
            check("match_state",   int'(bus.match_state),   got.state);
        end
    endtask

    task automatic send(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, bits[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    int fourth_step;
    int states_seen[$];

    initial begin
        rst           = 1'b0;
        bus.clear     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_count", int'(bus.pattern_count), 0);

        // Non-overlap 1,0,1,1,0,1,1 with idle gaps between bits
        pulse_steps = {};
        send(16'b1011, 4, 0);
        fourth_step = step_no;
        send(16'b011, 3, 1);
        check("nonov_pulses", pulse_steps.size(), 1);
        if (pulse_steps.size() > 0) check("nonov_latency", pulse_steps[0], fourth_step);
        check("nonov_count", int'(bus.pattern_count), 1);

        // Fallback on partial mismatch: 1,0,1,0,1,1 -> states 1,2,3,2,3,0
        step(1'b1, 1'b0, 1'b0, 1'b0);
        states_seen = {};
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] fb;
            fb = 6'b101011;
            step(1'b0, 1'b0, 1'b1, fb[i]);
            states_seen.push_back(int'(bus.match_state));
        end
        check("fb_s0", states_seen[0], 1);
        check("fb_s1", states_seen[1], 2);
        check("fb_s2", states_seen[2], 3);
        check("fb_s3", states_seen[3], 2);
        check("fb_s4", states_seen[4], 3);
        check("fb_s5", states_seen[5], 0);
        check("fb_count", int'(bus.pattern_count), 1);

        // Back-to-back valids: 1,0,1,1,1,0,1,1
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_steps = {};
        send(16'b10111011, 8, 0);
        check("b2b_pulses", pulse_steps.size(), 2);
        if (pulse_steps.size() == 2) check("b2b_gap", pulse_steps[1] - pulse_steps[0], 4);
        check("b2b_count", int'(bus.pattern_count), 2);

        // Saturation: 256 patterns
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_steps = {};
        for (int p = 0; p < 256; p++) send(16'b1011, 4, 0);
        check("sat_count", int'(bus.pattern_count), 255);
        check("sat_pulses", pulse_steps.size(), 256);
        check("sat_last_pulse", int'(bus.match_pulse), 1);

        // Reset mid-pattern, then a single 1
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b101, 3, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_steps = {};
        send(16'b1, 1, 0);
        check("rst_mid_state", int'(bus.match_state), 1);
        check("rst_mid_count", int'(bus.pattern_count), 0);
        check("rst_mid_pulses", pulse_steps.size(), 0);

        // Clear mid-pattern with a completing bit in the same cycle
        send(16'b01, 2, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        pulse_steps = {};
        send(16'b1, 1, 0);
        check("clr_mid_state", int'(bus.match_state), 1);
        check("clr_mid_count", int'(bus.pattern_count), 0);
        check("clr_mid_pulses", pulse_steps.size(), 0);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
